// File: rtl/lcd_serial_rx_if.sv
// Panel-driver serial bus and decoded receiver outputs for lcd_serial_rx.
interface lcd_serial_rx_if;
  logic [3:0] lcd;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] page;
  logic [6:0] column;
  logic       display_on;
  logic       frame_done;
  logic [7:0] abort_cnt;

  modport master (
    output lcd,
    input  byte_valid, byte_data, byte_is_data, wr_en, wr_addr, wr_data,
    input  page, column, display_on, frame_done, abort_cnt
  );

  modport slave (
    input  lcd,
    output byte_valid, byte_data, byte_is_data, wr_en, wr_addr, wr_data,
    output page, column, display_on, frame_done, abort_cnt
  );
endinterface

// File: rtl/lcd_serial_rx.sv
// Serial LCD controller receiver: synchronizes the panel bus, assembles bytes,
// decodes page/column/display commands and emits framebuffer writes.
module lcd_serial_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  lcd_serial_rx_if.slave bus
);

  localparam logic [3:0] IDLE_BUS = 4'b0001;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                        state;
  logic [SYNC_STAGES-1:0][3:0]   sync_q;
  logic                          scl_hist;
  logic [3:0]                    lcd_s;
  logic                          cs_n, scl_rise, a0_s, si_s;
  logic [7:0]                    shreg;
  logic [2:0]                    bit_cnt;
  logic                          a0_q;

  logic       byte_valid_q, byte_is_data_q, wr_en_q, display_on_q, frame_done_q;
  logic [7:0] byte_data_q, wr_data_q, abort_q;
  logic [9:0] wr_addr_q;
  logic [2:0] page_q;
  logic [6:0] col_q;

  assign lcd_s    = sync_q[SYNC_STAGES-1];
  assign cs_n     = lcd_s[0];
  assign scl_rise = lcd_s[1] & ~scl_hist;
  assign a0_s     = lcd_s[2];
  assign si_s     = lcd_s[3];

  // Input synchronizer chain; element 0 is the newest sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{IDLE_BUS}};
      scl_hist <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.lcd};
      scl_hist <= lcd_s[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= 8'h00;
      bit_cnt        <= 3'd0;
      a0_q           <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_data_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 10'd0;
      wr_data_q      <= 8'h00;
      page_q         <= 3'd0;
      col_q          <= 7'd0;
      display_on_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      abort_q        <= 8'h00;
    end else begin
      byte_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_n) begin
            state   <= SHIFT;
            bit_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          // A final bit arriving together with CS release still completes the byte.
          if (scl_rise && bit_cnt == 3'd7) begin
            shreg   <= {shreg[6:0], si_s};
            a0_q    <= a0_s;
            bit_cnt <= 3'd0;
            state   <= COMMIT;
          end else if (cs_n) begin
            if (bit_cnt != 3'd0 && abort_q != 8'hFF) abort_q <= abort_q + 8'd1;
            bit_cnt <= 3'd0;
            state   <= IDLE;
          end else if (scl_rise) begin
            shreg   <= {shreg[6:0], si_s};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        COMMIT: begin
          byte_valid_q   <= 1'b1;
          byte_data_q    <= shreg;
          byte_is_data_q <= a0_q;
          bit_cnt        <= 3'd0;
          state          <= cs_n ? IDLE : SHIFT;
          if (a0_q) begin
            wr_en_q      <= 1'b1;
            wr_addr_q    <= {page_q, col_q};
            wr_data_q    <= shreg;
            frame_done_q <= &{page_q, col_q};
            col_q        <= col_q + 7'd1;
          end else if (shreg[7:3] == 5'b10110) begin
            page_q <= shreg[2:0];
          end else if (shreg[7:4] == 4'h1) begin
            col_q[6:4] <= shreg[2:0];
          end else if (shreg[7:4] == 4'h0) begin
            col_q[3:0] <= shreg[3:0];
          end else if (shreg == 8'hAF) begin
            display_on_q <= 1'b1;
          end else if (shreg == 8'hAE) begin
            display_on_q <= 1'b0;
          end else if (shreg == 8'hE2) begin
            page_q       <= 3'd0;
            col_q        <= 7'd0;
            display_on_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_valid   = byte_valid_q;
  assign bus.byte_data    = byte_data_q;
  assign bus.byte_is_data = byte_is_data_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.page         = page_q;
  assign bus.column       = col_q;
  assign bus.display_on   = display_on_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.abort_cnt    = abort_q;

endmodule

// File: tb/tb_lcd_serial_rx.sv
// Self-checking bench for lcd_serial_rx: command table, corner sequences and
// randomized traffic against a byte-level model of the controller.
module tb_lcd_serial_rx;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n = 1'b1, scl = 1'b0, a0 = 1'b0, si = 1'b0;

  lcd_serial_rx_if bus_if ();
  assign bus_if.lcd = {si, a0, scl, cs_n};

  lcd_serial_rx #(.SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor (sole writer of the observation record)
  logic [18:0] obs_w [4096];
  int obs_n = 0, bv_seen = 0, fd_seen = 0, fd_stray = 0;
  always @(negedge clk) begin
    if (bus_if.wr_en && obs_n < 4096) begin
      obs_w[obs_n] = {bus_if.frame_done, bus_if.wr_addr, bus_if.wr_data};
      obs_n = obs_n + 1;
    end
    if (bus_if.byte_valid) bv_seen = bv_seen + 1;
    if (bus_if.frame_done) fd_seen = fd_seen + 1;
    if (bus_if.frame_done && !bus_if.wr_en) fd_stray = fd_stray + 1;
  end

  // Byte-level model of the controller registers
  int m_page = 0, m_col = 0, m_disp = 0, m_abort = 0, exp_bv = 0;
  logic [18:0] exp_q[$];
  int obs_rd = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic a0v);
    int addr;
    exp_bv++;
    if (a0v) begin
      addr = m_page * 128 + m_col;
      exp_q.push_back({(addr == 1023) ? 1'b1 : 1'b0, 10'(addr), b});
      m_col = (m_col + 1) % 128;
    end else if (b >= 8'hB0 && b <= 8'hB7) m_page = int'(b) - 176;
    else if (b >= 8'h10 && b <= 8'h1F) m_col = m_col % 16 + (int'(b) % 8) * 16;
    else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + int'(b);
    else if (b == 8'hAF) m_disp = 1;
    else if (b == 8'hAE) m_disp = 0;
    else if (b == 8'hE2) begin m_page = 0; m_col = 0; m_disp = 0; end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic a0v, input int nbits,
                           input int hi, input int lo);
    for (int i = 0; i < nbits; i++) begin
      scl = 1'b0; si = b[7-i]; a0 = a0v;
      cyc(lo);
      scl = 1'b1;
      cyc(hi);
    end
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a0v, input int hi, input int lo);
    send_bits(b, a0v, 8, hi, lo);
    model_byte(b, a0v);
  endtask

  task automatic cs_lo();
    cs_n = 1'b0; cyc(2);
  endtask

  task automatic cs_hi();
    scl = 1'b0; cs_n = 1'b1; cyc(S + 3);
  endtask

  task automatic settle();
    cyc(S + 6);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".page"}, int'(bus_if.page), m_page);
    chk({tag, ".column"}, int'(bus_if.column), m_col);
    chk({tag, ".display_on"}, int'(bus_if.display_on), m_disp);
    chk({tag, ".abort_cnt"}, int'(bus_if.abort_cnt), m_abort);
    chk({tag, ".byte_count"}, bv_seen, exp_bv);
  endtask

  // Compare every expected write against the observed stream, in order
  task automatic drain(input string tag);
    logic [18:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_n) begin
        chk({tag, ".write"}, int'(obs_w[obs_rd]), int'(e));
        obs_rd++;
      end else begin
        chk({tag, ".missing_write"}, 0, int'(e));
      end
    end
    chk({tag, ".extra_writes"}, obs_n - obs_rd, 0);
    obs_rd = obs_n;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       a0;
    int         page;
    int         col;
    int         disp;
    int         addr;
  } vec_t;

  vec_t vecs [12];
  logic [1023:0] hit;
  int n, fd0, nb, pick, hi, lo;
  logic [7:0] rb;

  initial begin
    vecs[0]  = '{8'hB3, 1'b0, 3, 7'h00, 0, -1};
    vecs[1]  = '{8'h12, 1'b0, 3, 7'h20, 0, -1};
    vecs[2]  = '{8'h05, 1'b0, 3, 7'h25, 0, -1};
    vecs[3]  = '{8'hA5, 1'b1, 3, 7'h26, 0, 10'h1A5};
    vecs[4]  = '{8'hAF, 1'b0, 3, 7'h26, 1, -1};
    vecs[5]  = '{8'hE2, 1'b0, 0, 7'h00, 0, -1};
    vecs[6]  = '{8'hB7, 1'b0, 7, 7'h00, 0, -1};
    vecs[7]  = '{8'h1F, 1'b0, 7, 7'h70, 0, -1};
    vecs[8]  = '{8'h0F, 1'b0, 7, 7'h7F, 0, -1};
    vecs[9]  = '{8'hFF, 1'b1, 7, 7'h00, 0, 10'h3FF};
    vecs[10] = '{8'h55, 1'b0, 7, 7'h00, 0, -1};
    vecs[11] = '{8'h0A, 1'b1, 7, 7'h01, 0, 10'h380};

    // Reset state
    cyc(3);
    chk("reset.outputs", int'({bus_if.byte_valid, bus_if.byte_data, bus_if.byte_is_data,
        bus_if.wr_en, bus_if.page, bus_if.column, bus_if.display_on, bus_if.frame_done,
        bus_if.abort_cnt}), 0);
    chk("reset.wr_bus", int'({bus_if.wr_addr, bus_if.wr_data}), 0);
    rst = 1'b0;
    cyc(3);

    // Command/data table in one CS window
    cs_lo();
    fd0 = fd_seen;
    for (int i = 0; i < 12; i++) begin
      send_byte(vecs[i].b, vecs[i].a0, 3, 3);
      settle();
      chk($sformatf("vec%0d.page", i), int'(bus_if.page), vecs[i].page);
      chk($sformatf("vec%0d.column", i), int'(bus_if.column), vecs[i].col);
      chk($sformatf("vec%0d.display_on", i), int'(bus_if.display_on), vecs[i].disp);
      chk($sformatf("vec%0d.byte_data", i), int'(bus_if.byte_data), int'(vecs[i].b));
      chk($sformatf("vec%0d.byte_is_data", i), int'(bus_if.byte_is_data), int'(vecs[i].a0));
      if (vecs[i].addr >= 0)
        chk($sformatf("vec%0d.wr_addr", i), int'(obs_w[obs_n-1][17:8]), vecs[i].addr);
    end
    cs_hi();
    chk("table.frame_done_count", fd_seen - fd0, 1);
    chk_regs("table");
    drain("table");

    // Latency from the pin-level 8th SCL rise to byte_valid/wr_en
    cs_lo();
    send_bits(8'hC3, 1'b1, 7, 3, 3);
    si = 1'b1; cyc(3);
    scl = 1'b1;
    model_byte(8'hC3, 1'b1);
    n = 0;
    while (!bus_if.byte_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency.cycles", n, S + 2);
    chk("latency.wr_en", int'(bus_if.wr_en), 1);
    cyc(1);
    chk("latency.pulse_width", int'({bus_if.byte_valid, bus_if.wr_en}), 0);
    scl = 1'b0;
    settle();

    // CS release coinciding with the 8th rise completes the byte
    send_bits(8'h96, 1'b1, 7, 3, 3);
    si = 1'b0; cyc(3);
    scl = 1'b1; cs_n = 1'b1;
    model_byte(8'h96, 1'b1);
    cyc(3); scl = 1'b0;
    settle();
    chk("samecycle.byte_data", int'(bus_if.byte_data), 8'h96);
    chk_regs("samecycle");
    drain("samecycle");

    // Abort after 5 bits, then a clean byte, then saturation
    cs_lo();
    send_bits(8'hFF, 1'b0, 5, 2, 2);
    cs_hi();
    m_abort++;
    chk_regs("abort1");
    cs_lo();
    send_byte(8'h3C, 1'b1, 2, 2);
    settle();
    chk("abort.next_byte", int'({bus_if.byte_is_data, bus_if.byte_data}), 9'h13C);
    cs_hi();
    for (int k = 0; k < 300; k++) begin
      cs_lo();
      nb = $urandom_range(1, 7);
      send_bits(8'($urandom), 1'($urandom), nb, 2, 2);
      cs_hi();
      if (m_abort < 255) m_abort++;
    end
    chk_regs("abort_sat");
    drain("abort");

    // Randomized traffic against the model
    cs_lo();
    for (int k = 0; k < 150; k++) begin
      pick = $urandom_range(0, 9);
      hi = $urandom_range(2, 4);
      lo = $urandom_range(2, 4);
      rb = 8'($urandom);
      case (pick)
        0, 1, 2, 3: send_byte(rb, 1'b1, hi, lo);
        4: send_byte(8'hB0 | 8'(rb[2:0]), 1'b0, hi, lo);
        5: send_byte(8'h10 | 8'(rb[3:0]), 1'b0, hi, lo);
        6: send_byte(8'h00 | 8'(rb[3:0]), 1'b0, hi, lo);
        7: send_byte(rb[0] ? 8'hAF : 8'hAE, 1'b0, hi, lo);
        8: send_byte(rb[7:5] == 3'd0 ? 8'hE2 : 8'hAF, 1'b0, hi, lo);
        default: send_byte(rb, 1'b0, hi, lo);
      endcase
      if ($urandom_range(0, 9) == 0) begin cs_hi(); cs_lo(); end
    end
    cs_hi();
    chk_regs("random");
    drain("random");

    // Full frame at minimum SCL width
    cs_lo();
    fd0 = fd_seen;
    n = obs_n;
    send_byte(8'hB0, 1'b0, 2, 2);
    send_byte(8'h10, 1'b0, 2, 2);
    send_byte(8'h00, 1'b0, 2, 2);
    for (int p = 0; p < 8; p++) begin
      if (p > 0) send_byte(8'hB0 | 8'(p), 1'b0, 2, 2);
      for (int c = 0; c < 128; c++) send_byte(8'($urandom), 1'b1, 2, 2);
    end
    settle();
    cs_hi();
    hit = '0;
    for (int k = n; k < obs_n; k++) hit[obs_w[k][17:8]] = 1'b1;
    chk("frame.addresses_hit", $countones(hit), 1024);
    chk("frame.frame_done_count", fd_seen - fd0, 1);
    chk("frame.page_after", int'(bus_if.page), 7);
    chk("frame.fd_without_wr", fd_stray, 0);
    chk_regs("frame");
    drain("frame");

    // Reset in the middle of a byte
    cs_lo();
    send_byte(8'hB4, 1'b0, 2, 2);
    send_byte(8'hAF, 1'b0, 2, 2);
    settle();
    chk_regs("prereset");
    send_bits(8'hB5, 1'b0, 4, 2, 2);
    rst = 1'b1;
    #1;
    chk("midreset.outputs", int'({bus_if.byte_valid, bus_if.byte_data, bus_if.byte_is_data,
        bus_if.wr_en, bus_if.page, bus_if.column, bus_if.display_on, bus_if.frame_done,
        bus_if.abort_cnt}), 0);
    chk("midreset.wr_bus", int'({bus_if.wr_addr, bus_if.wr_data}), 0);
    m_page = 0; m_col = 0; m_disp = 0; m_abort = 0;
    cs_n = 1'b1; scl = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    cs_lo();
    send_byte(8'hB5, 1'b0, 2, 2);
    settle();
    cs_hi();
    chk("postreset.page", int'(bus_if.page), 5);
    chk_regs("postreset");
    drain("postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule
